if_id_stage: RTL

- Fetch front end that responds to the hazard-detection unit's stall requests and to ID-stage branch flushes.
- Owns the PC register, the instruction-memory request handshake, and the IF/ID pipeline register.
- Freezes, bubbles or redirects fetch so ID always sees a coherent instruction/PC pair.
- Sits between instruction memory and the decode stage of the 5-stage MIPS pipeline.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_skid_buf.sv | 50 +++++
 rtl/if_id_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the IF/ID fetch front end.
package if_pkg;

    localparam int unsigned PC_INC      = 4;
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction/pc+4 pair that was
// acknowledged by memory while decode was stalled.
module if_skid_buf
    import if_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_plus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus4_o,
    output logic               full_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_plus4_q;
    logic               full_q;

    // NOTE: sequential state is always written with <= so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else if (clear_i || drain_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
        end
    end

    // NOTE: the payload is qualified by full_q, so it needs no reset;
    // only the control flag is reset.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign full_o     = full_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, instruction-memory handshake and IF/ID register.
// Optional stall/flush performance counters are enabled with IF_PERF_CNT_EN.
module if_id_stage
    import if_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               pc_stall_i,
    input  logic               stallHold_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus4_o,
`ifdef IF_PERF_CNT_EN
    output logic               valid_o,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
`else
    output logic               valid_o
`endif
);

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next_seq;
    logic [ADDR_W-1:0]  redir_tgt;
    logic               redir_pend;
    logic               stall;

    logic               skid_load;
    logic               skid_drain;
    logic               skid_clear;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc_plus4;
    logic               skid_full;

    assign stall       = pc_stall_i | stallHold_i;
    assign pc_next_seq = pc + ADDR_W'(PC_INC);

    // A word acknowledged during a pending redirect is from the wrong path
    // and must never reach the skid buffer.
    assign skid_load  = (state == FETCH) && imem_ack_i && stall && !flush_i && !redir_pend;
    assign skid_drain = (state == STALL) && !stall && !flush_i;
    assign skid_clear = (state == STALL) && flush_i;

    assign imem_req_o  = (state == FETCH);
    assign imem_addr_o = pc;

    if_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (skid_load),
        .drain_i    (skid_drain),
        .clear_i    (skid_clear),
        .instr_i    (imem_data_i),
        .pc_plus4_i (pc_next_seq),
        .instr_o    (skid_instr),
        .pc_plus4_o (skid_pc_plus4),
        .full_o     (skid_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_tgt  <= RESET_PC;
            redir_pend <= 1'b0;
            instr_o    <= NOP_INSTR;
            pc_plus4_o <= '0;
            valid_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (flush_i) begin
                        instr_o    <= NOP_INSTR;
                        pc_plus4_o <= '0;
                        valid_o    <= 1'b0;
                        if (imem_ack_i) begin
                            pc         <= branch_target_i;
                            redir_pend <= 1'b0;
                        end else begin
                            // Keep the outstanding address stable until memory answers.
                            redir_tgt  <= branch_target_i;
                            redir_pend <= 1'b1;
                        end
                    end else if (redir_pend) begin
                        if (imem_ack_i) begin
                            pc         <= redir_tgt;
                            redir_pend <= 1'b0;
                        end
                    end else if (imem_ack_i) begin
                        if (stall) begin
                            state <= STALL;
                        end else begin
                            instr_o    <= imem_data_i;
                            pc_plus4_o <= pc_next_seq;
                            valid_o    <= 1'b1;
                            pc         <= pc_next_seq;
                        end
                    end
                end

                STALL: begin
                    if (flush_i) begin
                        instr_o    <= NOP_INSTR;
                        pc_plus4_o <= '0;
                        valid_o    <= 1'b0;
                        pc         <= branch_target_i;
                        state      <= FETCH;
                    end else if (!stall) begin
                        instr_o    <= skid_instr;
                        pc_plus4_o <= skid_pc_plus4;
                        valid_o    <= skid_full;
                        pc         <= pc_next_seq;
                        state      <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if ((state != IDLE) && stall && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if ((state != IDLE) && flush_i && (flush_cnt_o != 32'hFFFF_FFFF)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
